// File: rtl/wb_ram_target.sv
// Wishbone pipelined byte-RAM target with 0..3 configurable wait states per request.
// Optional write protection of offsets >= ROM_BASE when WB_TARGET_ROM_WP_EN is defined.
module wb_ram_target #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned WAIT_STATES   = 0,
  parameter int unsigned ROM_BASE      = 'h800
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic                     wb_we_i,
  input  logic                     wb_cycle_i,
  input  logic                     wb_strobe_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o
);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  localparam logic [1:0] WaitInit = 2'(WAIT_STATES);

  state_e                  state_q, state_d;
  logic [1:0]              count_q, count_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  logic                    accept;
  logic                    access;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    wr_ok;
  logic                    wr_en;
  logic                    unused_addr_hi;

  assign req_addr       = wb_addr_i[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^wb_addr_i;

  assign wb_stall_o = (state_q == StWait);
  assign wb_ack_o   = (state_q == StAck);
  assign wb_data_o  = rdata_q;
  assign accept     = wb_cycle_i & wb_strobe_i & ~wb_stall_o;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      StIdle, StAck: begin
        state_d = StIdle;
        if (accept) begin
          if (WAIT_STATES == 0) begin
            // Zero wait states: the accept edge is also the access edge.
            access    = 1'b1;
            acc_we    = wb_we_i;
            acc_addr  = req_addr;
            acc_wdata = wb_data_i;
            state_d   = StAck;
          end else begin
            state_d = StWait;
            count_d = WaitInit;
          end
        end
      end
      StWait: begin
        if (!wb_cycle_i) begin
          state_d = StIdle;
          count_d = 2'd0;
        end else begin
          count_d = count_q - 2'd1;
          if (count_q == 2'd1) begin
            access  = 1'b1;
            state_d = StAck;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef WB_TARGET_ROM_WP_EN
  localparam logic [ADDR_WIDTH-1:0] RomBase = ADDR_WIDTH'(ROM_BASE);
  assign wr_ok = (acc_addr < RomBase);
`else
  localparam int unsigned unused_rom_base = ROM_BASE;
  assign wr_ok = 1'b1;
`endif

  assign wr_en = access & acc_we & wr_ok;

  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q <= StIdle;
      count_q <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= wb_data_i;
        we_q    <= wb_we_i;
      end
      if (access && !acc_we) begin
        rdata_q <= mem[acc_addr];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge wb_clock_i) begin
    if (wr_en) begin
      mem[acc_addr] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_wb_ram_target.sv
// Directed bench for wb_ram_target: a zero-wait instance and a two-wait-state instance.
module tb_wb_ram_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [15:0] a0, a2;
  logic [7:0]  di0, di2, do0, do2;
  logic        we0, we2, cyc0, cyc2, stb0, stb2;
  logic        stall0, stall2, ack0, ack2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned stall0_hi = 0;
  logic [7:0]  rom_old;

  always #5 clk = ~clk;

  wb_ram_target #(.WB_ADDR_WIDTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(12), .WAIT_STATES(0),
                  .ROM_BASE('h800)) dut0 (
    .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(a0), .wb_data_i(di0), .wb_data_o(do0),
    .wb_we_i(we0), .wb_cycle_i(cyc0), .wb_strobe_i(stb0), .wb_stall_o(stall0), .wb_ack_o(ack0)
  );

  wb_ram_target #(.WB_ADDR_WIDTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(12), .WAIT_STATES(2),
                  .ROM_BASE('h800)) dut2 (
    .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(a2), .wb_data_i(di2), .wb_data_o(do2),
    .wb_we_i(we2), .wb_cycle_i(cyc2), .wb_strobe_i(stb2), .wb_stall_o(stall2), .wb_ack_o(ack2)
  );

  always @(posedge clk) if (rst_n && stall0) stall0_hi++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step0(input logic c, input logic s, input logic w, input logic [15:0] a,
                       input logic [7:0] d);
    cyc0 = c; stb0 = s; we0 = w; a0 = a; di0 = d;
    @(posedge clk); #1;
  endtask

  task automatic step2(input logic c, input logic s, input logic w, input logic [15:0] a,
                       input logic [7:0] d);
    cyc2 = c; stb2 = s; we2 = w; a2 = a; di2 = d;
    @(posedge clk); #1;
  endtask

  initial begin
    {cyc0, stb0, we0, a0, di0} = '0;
    {cyc2, stb2, we2, a2, di2} = '0;
    #1;
    check("rst ack0", ack0, 0);
    check("rst stall0", stall0, 0);
    check("rst data0", do0, 0);
    check("rst stall2", stall2, 0);
    check("rst data2", do2, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait back-to-back traffic
    step0(1, 1, 1, 16'h0010, 8'hA5); check("w0 ack", ack0, 1); check("w0 data", do0, 8'h00);
    step0(1, 1, 0, 16'h0010, 8'h00); check("r0 ack", ack0, 1); check("r0 data", do0, 8'hA5);
    step0(1, 1, 1, 16'h1020, 8'h5A); check("w1 ack", ack0, 1); check("w1 hold", do0, 8'hA5);
    step0(1, 1, 0, 16'h0020, 8'h00); check("r1 ack", ack0, 1); check("r1 data", do0, 8'h5A);
    step0(1, 1, 0, 16'h1010, 8'h00); check("wrap ack", ack0, 1); check("wrap data", do0, 8'hA5);
    step0(0, 0, 0, 16'h0000, 8'h00); check("idle ack", ack0, 0);
    step0(0, 1, 0, 16'h0020, 8'h00); check("stb no cyc", ack0, 0); check("stb no cyc d", do0, 8'hA5);
    step0(1, 0, 0, 16'h0020, 8'h00); check("cyc no stb", ack0, 0);
    step0(1, 1, 1, 16'h0030, 8'h33); check("w2 ack", ack0, 1); check("w2 hold", do0, 8'hA5);
    step0(1, 1, 0, 16'h0030, 8'h00); check("r2 data", do0, 8'h33);

    // Write-protect boundary at 0x800
`ifdef WB_TARGET_ROM_WP_EN
    step0(1, 1, 0, 16'h0800, 8'h00); rom_old = do0;
`endif
    step0(1, 1, 1, 16'h0800, 8'h77); check("rom w800 ack", ack0, 1);
    step0(1, 1, 1, 16'h07FF, 8'h77); check("rom w7ff ack", ack0, 1);
    step0(1, 1, 0, 16'h07FF, 8'h00); check("rom r7ff", do0, 8'h77);
    step0(1, 1, 0, 16'h0030, 8'h00); check("rom sep", do0, 8'h33);
    step0(1, 1, 0, 16'h0800, 8'h00);
`ifdef WB_TARGET_ROM_WP_EN
    check("rom r800 protected", do0, rom_old);
`else
    check("rom r800 written", do0, 8'h77);
`endif
    step0(0, 0, 0, 16'h0000, 8'h00); check("end ack0", ack0, 0);
    check("stall0 never", stall0_hi, 0);

    // Two wait states: write, then read accepted in the ack cycle
    step2(1, 1, 1, 16'h0040, 8'h11); check("ws w acc stall", stall2, 1); check("ws w acc ack", ack2, 0);
    step2(1, 0, 0, 16'h0040, 8'h00); check("ws w wait stall", stall2, 1); check("ws w wait ack", ack2, 0);
    step2(1, 0, 0, 16'h0040, 8'h00); check("ws w ack", ack2, 1); check("ws w ack stall", stall2, 0);
    step2(1, 1, 0, 16'h0040, 8'h00); check("ws r b2b stall", stall2, 1); check("ws r b2b ack", ack2, 0);
    step2(1, 0, 0, 16'h0040, 8'h00); check("ws r wait", stall2, 1);
    step2(1, 0, 0, 16'h0040, 8'h00); check("ws r ack", ack2, 1); check("ws r data", do2, 8'h11);
    step2(0, 0, 0, 16'h0000, 8'h00); check("ws idle ack", ack2, 0); check("ws idle stall", stall2, 0);

    // Abort a write by dropping cycle during the wait
    step2(1, 1, 1, 16'h0040, 8'h3C); check("abort acc", stall2, 1);
    step2(0, 0, 0, 16'h0040, 8'h00); check("abort stall", stall2, 0); check("abort ack", ack2, 0);
    step2(0, 0, 0, 16'h0000, 8'h00); check("abort late ack", ack2, 0);
    step2(1, 1, 0, 16'h0040, 8'h00);
    step2(1, 0, 0, 16'h0040, 8'h00);
    step2(1, 0, 0, 16'h0040, 8'h00); check("abort r ack", ack2, 1); check("abort r data", do2, 8'h11);
    step2(0, 0, 0, 16'h0000, 8'h00);

    // Reset in the middle of a wait
    step2(1, 1, 1, 16'h0040, 8'h99); check("rstw acc", stall2, 1);
    cyc2 = 1'b0; stb2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rstw stall", stall2, 0); check("rstw ack", ack2, 0); check("rstw data", do2, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step2(0, 0, 0, 16'h0000, 8'h00); check("rstw post ack a", ack2, 0);
    step2(0, 0, 0, 16'h0000, 8'h00); check("rstw post ack b", ack2, 0);
    step2(0, 0, 0, 16'h0000, 8'h00); check("rstw post ack c", ack2, 0);
    step2(1, 1, 0, 16'h1040, 8'h00);
    step2(1, 0, 0, 16'h0040, 8'h00);
    step2(1, 0, 0, 16'h0040, 8'h00); check("rstw r ack", ack2, 1); check("rstw r data", do2, 8'h11);
    step2(0, 0, 0, 16'h0000, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_ram_target.md
WB_RAM_TARGET -- requirements
Module: wb_ram_target

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, number of low wb_addr_i bits decoded (4 KiB byte array).
REQ-002 Parameter WAIT_STATES, default 0, range 0..3, extra stall cycles inserted per accepted request.
REQ-003 Parameter ROM_BASE, default 12'h800, lowest write-protected offset (used only when WB_TARGET_ROM_WP_EN is defined).
REQ-004 wb_clock_i  input  1  single bus clock; all state changes on its rising edge.
REQ-005 wb_reset_ni  input  1  asynchronous, active-low reset.
REQ-006 wb_addr_i  input  WB_ADDR_WIDTH  request address; only bits [ADDR_WIDTH-1:0] used.
REQ-007 wb_data_i  input  DATA_WIDTH  write data.
REQ-008 wb_data_o  output  DATA_WIDTH  read data, valid when wb_ack_o asserted for a read.
REQ-009 wb_we_i  input  1  0 = read, 1 = write.
REQ-010 wb_cycle_i  input  1  initiator owns the bus.
REQ-011 wb_strobe_i  input  1  request valid.
REQ-012 wb_stall_o  output  1  target cannot accept a request this cycle.
REQ-013 wb_ack_o  output  1  one-cycle termination of exactly one accepted request.

Function
REQ-014 Request accepted on rising edge where wb_cycle_i && wb_strobe_i && !wb_stall_o; strobe without cycle ignored.
REQ-015 Accept latches offset, data, we; memory operation executes at the "access edge".
REQ-016 FSM states IDLE, WAIT, ACK; IDLE: stall_o=0; accept -> WAIT (count=WAIT_STATES) if WAIT_STATES>0, else access edge = accept edge -> ACK.
REQ-017 WAIT: stall_o=1; count decrements each edge; edge with count==1 is the access edge -> ACK.
REQ-018 ACK: wb_ack_o=1 for exactly one cycle, stall_o=0; a new request accepted in ACK behaves as in IDLE (back-to-back).
REQ-019 Latency: ack in cycle accept+1+WAIT_STATES; WAIT_STATES=0 sustains one transfer per clock.
REQ-020 Read: wb_data_o = mem[offset] registered at access edge; held until next read access.
REQ-021 Write: mem[offset] <= wb_data_i at access edge; wb_data_o unchanged.
REQ-022 Operations execute in acceptance order; read following write to same offset returns written value.
REQ-023 Abort: wb_cycle_i low in WAIT -> IDLE on next edge, no access, no ack; wb_cycle_i low in ACK suppresses nothing already registered but no new accept.
REQ-024 Acks never issued without a preceding accept; outstanding requests never exceed one (beyond the one being acked).
REQ-025 Offset wraps modulo 2^ADDR_WIDTH; upper address bits ignored.

Reset
REQ-026 wb_reset_ni low: immediately wb_ack_o=0, wb_stall_o=0, wb_data_o=0, state IDLE, count 0.
REQ-027 Reset mid-WAIT cancels pending request; no write performed, no ack after release.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 Macro WB_TARGET_ROM_WP_EN defined: writes with offset >= ROM_BASE are acked with normal timing but memory unchanged.
REQ-030 WB_TARGET_ROM_WP_EN undefined: all writes performed; ROM_BASE ignored; no protection logic synthesized.

Verification
REQ-031 WAIT_STATES=0: write 8'hA5 @0x010, read 0x010 next cycle -> acks in consecutive cycles, read data 8'hA5, stall_o never high.
REQ-032 WAIT_STATES=2: single read -> stall_o high 2 cycles, ack in cycle accept+3, next accept allowed in ack cycle.
REQ-033 WAIT_STATES=2: write 8'h3C, drop wb_cycle_i after 1 wait cycle -> no ack; later read returns prior value.
REQ-034 Assert wb_reset_ni low during WAIT -> outputs 0 asynchronously; no ack after release; memory keeps earlier data.
REQ-035 WB_TARGET_ROM_WP_EN defined, ROM_BASE=0x800: write 8'h77 @0x800 and @0x7FF -> both acked; readback 0x800 old value, 0x7FF 8'h77.
REQ-036 Address 0x1010 with ADDR_WIDTH=12 -> accesses offset 0x010.
